imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time loader that sequences writes into the 1024-word MIPS instruction memory from an 8-bit valid/ready byte stream (UART or debug bridge). It parses a 16-bit word-count header, packs big-endian bytes into 32-bit instructions, and issues one registered write per word at sequential word-aligned byte addresses. It also holds the CPU fetch path in stall for the whole load. The block sits between the host byte source and the instruction memory write port, beside the CPU.

## Interface
- ADDR_WIDTH, 10, word-address width; capacity = 2^ADDR_WIDTH words
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle load request
- in_valid  in  1  byte source has data
- in_data  in  8  byte from source
- in_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  instruction memory write strobe, one cycle per word
- mem_waddr  out  32  byte address of write, word aligned (memory indexes addr>>2)
- mem_wdata  out  32  instruction word
- cpu_hold  out  1  stall CPU fetch/PC while high
- busy  out  1  load in progress
- done  out  1  sticky: last load completed
- err  out  1  sticky: header word count exceeded capacity

## Operation
- States: IDLE, LEN, DATA, FLUSH, DONE, ERR.
- IDLE/DONE/ERR + start → LEN. Clears done and err, word index and byte counter. start in LEN, DATA or FLUSH is ignored.
- LEN: accepts 2 bytes, high byte first, giving N.
  - N == 0 → DONE.
  - N > 2^ADDR_WIDTH → ERR.
  - Otherwise → DATA.
- DATA: each byte shifts into the packer, MSB first (byte 0 → bits 31:24). On the 4th byte of word k, the word and address 4k are registered and mem_we pulses next cycle. k increments. The byte counter wraps 3→0.
- When the 4th byte of word N-1 is accepted → FLUSH. FLUSH presents the final write (mem_we=1) → DONE.
- in_ready = 1 in LEN and DATA only. A byte transfers iff in_valid && in_ready. in_valid gaps stall the FSM indefinitely, with no timeout.
- cpu_hold = busy = 1 in LEN, DATA, FLUSH. Both are 0 otherwise.
- done = 1 in DONE. err = 1 in ERR. Both are held until the next start or reset.
- mem_waddr/mem_wdata hold their last value when mem_we = 0.
- Address arithmetic: k is ADDR_WIDTH+1 bits. mem_waddr = {zeros, k[ADDR_WIDTH-1:0], 2'b00}. N = 2^ADDR_WIDTH is legal and fills memory exactly.

## Timing
- Reset (async assert): all outputs 0, state IDLE. cpu_hold = 0 so a preloaded program runs after reset.
- start at cycle 0 → LEN, in_ready/busy/cpu_hold = 1 from cycle 1.
- Byte transfer latency: 4th byte of a word accepted at cycle t → mem_we = 1 at t+1. In DATA, in_ready stays 1 during that write cycle. Back-to-back words sustain 1 byte/cycle.
- Last byte accepted at t:
  - t+1: FLUSH, mem_we = 1, in_ready = 0.
  - t+2: DONE, cpu_hold = 0, done = 1.
- Second length byte accepted at t, N = 0: DONE at t+1, no writes. Oversize N: ERR at t+1, no writes.
- Reset mid-load returns to IDLE immediately. Words already written stay in memory. No partial word is written.

## Structure
- Package imem_loader_pkg:
  - state enum (IDLE, LEN, DATA, FLUSH, DONE, ERR)
  - LEN_BYTES = 2
  - BYTES_PER_WORD = 4
- Sub-module byte_word_packer contains the 32-bit shift register, the 2-bit byte counter and the word_complete pulse. The FSM, address counter and write register stay in the top.

## Test plan
- Reset then idle: outputs all 0. start with N=3, bytes 20 11 00 28 / 20 12 00 50 / 02 20 40 20 at full rate → writes 0x20110028@0x0, 0x20120050@0x4, 0x02204020@0x8, each one cycle after its 4th byte. done 2 cycles after last byte. cpu_hold high exactly over the load.
- Same load with in_valid toggled randomly 50% → identical write sequence, no extra or missing mem_we.
- Header 00 00 → DONE one cycle after 2nd byte, zero writes, done=1. Header 04 01 (1025 words) → ERR, err=1, in_ready=0, zero writes.
- N=1024 → last write at address 0xFFC, then done. No address wrap to 0.
- start asserted in DATA → ignored, load completes unchanged. rst_n pulsed after 6 data bytes → immediate IDLE, only word 0 written, cpu_hold=0.
- Load completes, then start again with N=1 → done/err cleared on start, new word written at address 0x0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory boot loader.
//   - state_e        : loader FSM states
//   - LEN_BYTES      : number of header bytes carrying the word count
//   - BYTES_PER_WORD : bytes packed into one 32-bit instruction
//   - helper functions that classify states for start/ready/busy decoding
// -----------------------------------------------------------------------------
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN   = 3'd1,
      DATA  = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_e;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

   // A new load may only begin from a resting state.
   function automatic logic accepts_start(input state_e s);
      return (s == IDLE) || (s == DONE) || (s == ERR);
   endfunction

   // States in which the byte source is allowed to transfer.
   function automatic logic takes_bytes(input state_e s);
      return (s == LEN) || (s == DATA);
   endfunction

   // States in which the CPU must be kept off the instruction memory.
   function automatic logic is_loading(input state_e s);
      return (s == LEN) || (s == DATA) || (s == FLUSH);
   endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
//   Packs a big-endian byte stream into 32-bit words. The first byte of a
//   word lands in bits 31:24. word_complete_o pulses combinationally in the
//   cycle the final byte of a word is presented, and word_o already contains
//   that byte, so the consumer can register the full word on the same edge.
//
// Ports
//   clk             : system clock
//   rst_n           : asynchronous active-low reset
//   clr_i           : restart packing at byte 0 (new load)
//   byte_valid_i    : a data byte is transferred this cycle
//   byte_i          : the data byte
//   word_o          : assembled word including the current byte
//   word_complete_o : current byte finishes a word
// -----------------------------------------------------------------------------
module byte_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_complete_o
);

   // Only the three earlier bytes need storage; the fourth is taken straight
   // from the input when the word completes.
   logic [23:0]           shift_q, shift_d;
   logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

   localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clr_i) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (byte_valid_i) begin
         shift_d = {shift_q[15:0], byte_i};
         cnt_d   = cnt_q + 1'b1;   // wraps 3 -> 0 naturally
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign word_o          = {shift_q, byte_i};
   assign word_complete_o = byte_valid_i && !clr_i && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time loader for the MIPS instruction memory. Reads a 16-bit word
//   count (high byte first) from a valid/ready byte stream, then packs the
//   following big-endian bytes into 32-bit instructions and writes them to
//   sequential word-aligned byte addresses starting at 0. The CPU fetch path
//   is held in stall for the whole load.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : single-cycle load request (honoured in IDLE/DONE/ERR only)
//   in_valid  : byte source has data
//   in_data   : byte from source
//   in_ready  : loader accepts a byte this cycle
//   mem_we    : instruction memory write strobe, one cycle per word
//   mem_waddr : write byte address (word aligned)
//   mem_wdata : instruction word
//   cpu_hold  : stall CPU fetch/PC
//   busy      : load in progress
//   done      : sticky, last load completed
//   err       : sticky, header count exceeded capacity
// -----------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // Word count is compared in 17 bits so that N = 2^16-1 against a capacity
   // of up to 2^16 never overflows.
   localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

   state_e                state_q, state_d;
   logic                  len_idx_q, len_idx_d;     // header byte index
   logic [7:0]            len_hi_q, len_hi_d;       // stored header high byte
   logic [ADDR_WIDTH:0]   n_q, n_d;                 // words to load
   logic [ADDR_WIDTH:0]   k_q, k_d;                 // next word index
   logic                  we_q, we_d;
   logic [31:0]           waddr_q, waddr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  in_ready_q, in_ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  byte_xfer;
   logic                  start_ok;
   logic                  data_byte;
   logic [16:0]           hdr_n_ext;
   logic [ADDR_WIDTH:0]   k_inc;
   logic [31:0]           packed_word;
   logic                  word_complete;

   assign byte_xfer = in_valid && in_ready_q;
   assign start_ok  = start && accepts_start(state_q);
   assign data_byte = byte_xfer && (state_q == DATA);
   assign hdr_n_ext = {1'b0, len_hi_q, in_data};
   assign k_inc     = k_q + 1'b1;

   byte_word_packer u_packer (
      .clk             (clk),
      .rst_n           (rst_n),
      .clr_i           (start_ok),
      .byte_valid_i    (data_byte),
      .byte_i          (in_data),
      .word_o          (packed_word),
      .word_complete_o (word_complete)
   );

   always_comb begin
      state_d   = state_q;
      len_idx_d = len_idx_q;
      len_hi_d  = len_hi_q;
      n_d       = n_q;
      k_d       = k_q;
      we_d      = word_complete;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;

      // Capture the finished word together with its address; the write
      // strobe follows one cycle later from the registers.
      if (word_complete) begin
         waddr_d = {{(30 - ADDR_WIDTH){1'b0}}, k_q[ADDR_WIDTH-1:0], 2'b00};
         wdata_d = packed_word;
         k_d     = k_inc;
      end

      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d   = LEN;
               len_idx_d = 1'b0;
               k_d       = '0;
            end
         end
         LEN: begin
            if (byte_xfer) begin
               if (len_idx_q == 1'(LEN_BYTES - 1)) begin
                  if (hdr_n_ext == 17'd0) begin
                     state_d = DONE;
                  end else if (hdr_n_ext > CAPACITY) begin
                     state_d = ERR;
                  end else begin
                     n_d     = hdr_n_ext[ADDR_WIDTH:0];
                     state_d = DATA;
                  end
               end else begin
                  len_hi_d  = in_data;
                  len_idx_d = len_idx_q + 1'b1;
               end
            end
         end
         DATA: begin
            // k_inc is ADDR_WIDTH+1 bits so N = 2^ADDR_WIDTH terminates
            // cleanly instead of wrapping back to address 0.
            if (word_complete && (k_inc == n_q)) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status outputs are registered from the next state so they line up
      // with the state register itself.
      in_ready_d = takes_bytes(state_d);
      busy_d     = is_loading(state_d);
      done_d     = (state_d == DONE);
      err_d      = (state_d == ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_idx_q  <= 1'b0;
         len_hi_q   <= '0;
         n_q        <= '0;
         k_q        <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_idx_q  <= len_idx_d;
         len_hi_q   <= len_hi_d;
         n_q        <= n_d;
         k_q        <= k_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = we_q;
   assign mem_waddr = waddr_q;
   assign mem_wdata = wdata_q;
   assign cpu_hold  = busy_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. Inputs change on the falling edge and
//   outputs are sampled on the falling edge. A monitor logs every write with
//   its sample time so write timing can be compared against the time the
//   fourth byte of each word was accepted.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;

   imem_loader #(.ADDR_WIDTH(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          checks = 0;
   int          errors = 0;

   // write log
   logic [31:0] wa [0:1023];
   logic [31:0] wd [0:1023];
   time         wt [0:1023];
   int          wr_cnt = 0;

   // acceptance time of each data byte of the current load
   time         bt [0:4095];
   int          nb = 0;

   logic [31:0] exp_w [0:1023];

   always @(negedge clk) begin
      if (rst_n === 1'b1 && mem_we === 1'b1) begin
         if (wr_cnt < 1024) begin
            wa[wr_cnt] = mem_waddr;
            wd[wr_cnt] = mem_wdata;
            wt[wr_cnt] = $time;
         end
         wr_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after acceptance.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int t;
      t = 0;
      if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         chk("ready_timeout", 32'(in_ready), 1);
      end else begin
         @(posedge clk);
         if (nb < 4096) bt[nb] = $time;
         nb++;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int j = 0; j < 4; j++) send_byte(w[31-8*j -: 8], gaps);
   endtask

   task automatic do_start();
      wr_cnt = 0;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      chk("start_in_ready", 32'(in_ready), 1);
      chk("start_busy", 32'(busy), 1);
      chk("start_cpu_hold", 32'(cpu_hold), 1);
      chk("start_done_clr", 32'(done), 0);
      chk("start_err_clr", 32'(err), 0);
   endtask

   task automatic send_header(input int n);
      logic [15:0] h;
      h = 16'(n);
      send_byte(h[15:8], 1'b0);
      send_byte(h[7:0], 1'b0);
      nb = 0;
   endtask

   // Entered on the falling edge right after the final data byte.
   task automatic finish_load();
      chk("flush_we", 32'(mem_we), 1);
      chk("flush_in_ready", 32'(in_ready), 0);
      chk("flush_cpu_hold", 32'(cpu_hold), 1);
      @(negedge clk);
      chk("done_flag", 32'(done), 1);
      chk("done_cpu_hold", 32'(cpu_hold), 0);
      chk("done_busy", 32'(busy), 0);
      chk("done_we", 32'(mem_we), 0);
      chk("done_err", 32'(err), 0);
   endtask

   task automatic check_writes(input int n);
      chk("wr_count", 32'(wr_cnt), 32'(n));
      for (int i = 0; i < n && i < 1024; i++) begin
         chk($sformatf("wr_addr[%0d]", i), wa[i], 32'(i * 4));
         chk($sformatf("wr_data[%0d]", i), wd[i], exp_w[i]);
         chk($sformatf("wr_time[%0d]", i), 32'(wt[i]), 32'(bt[4*i+3] + 5));
      end
   endtask

   task automatic run_load(input int n, input bit gaps);
      do_start();
      send_header(n);
      for (int i = 0; i < n; i++) send_word(exp_w[i], gaps);
      finish_load();
      @(negedge clk);
      check_writes(n);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_waddr", mem_waddr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_cpu_hold", 32'(cpu_hold), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_in_ready", 32'(in_ready), 0);

      // three-word load, full rate
      exp_w[0] = 32'h20110028;
      exp_w[1] = 32'h20120050;
      exp_w[2] = 32'h02204020;
      run_load(3, 1'b0);
      $display("load N=3 full rate: %0d writes", wr_cnt);
      @(negedge clk);
      chk("hold_wdata", mem_wdata, 32'h02204020);
      chk("hold_waddr", mem_waddr, 32'h8);

      // same load with random valid gaps (start from DONE clears done)
      run_load(3, 1'b1);
      $display("load N=3 with gaps: %0d writes", wr_cnt);

      // zero-length header
      do_start();
      send_header(0);
      chk("n0_done", 32'(done), 1);
      chk("n0_busy", 32'(busy), 0);
      chk("n0_in_ready", 32'(in_ready), 0);
      @(negedge clk);
      chk("n0_writes", 32'(wr_cnt), 0);
      $display("load N=0: done=%0b writes=%0d", done, wr_cnt);

      // oversize header: 1025 words
      do_start();
      send_header(1025);
      chk("big_err", 32'(err), 1);
      chk("big_done", 32'(done), 0);
      chk("big_in_ready", 32'(in_ready), 0);
      chk("big_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
      chk("big_writes", 32'(wr_cnt), 0);
      chk("big_err_sticky", 32'(err), 1);
      $display("load N=1025: err=%0b writes=%0d", err, wr_cnt);

      // restart from ERR with N=1 (start clears err)
      exp_w[0] = 32'hDEADBEEF;
      run_load(1, 1'b0);
      $display("load N=1 after error: %0d writes", wr_cnt);

      // start pulsed during DATA is ignored
      exp_w[0] = 32'h8C080004;
      exp_w[1] = 32'hAC090008;
      do_start();
      send_header(2);
      send_word(exp_w[0], 1'b0);
      send_byte(8'hAC, 1'b0);
      send_byte(8'h09, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_busy", 32'(busy), 1);
      chk("ign_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      chk("ign_busy2", 32'(busy), 1);
      send_byte(8'h00, 1'b0);
      send_byte(8'h08, 1'b0);
      finish_load();
      @(negedge clk);
      check_writes(2);
      $display("load N=2 with stray start: %0d writes", wr_cnt);

      // full memory, N=1024
      for (int i = 0; i < 1024; i++) exp_w[i] = 32'hC0DE0000 | 32'(i);
      run_load(1024, 1'b0);
      chk("full_last_addr", wa[1023], 32'hFFC);
      $display("load N=1024: %0d writes, last addr %0h", wr_cnt, wa[1023]);

      // reset after six data bytes
      exp_w[0] = 32'h11223344;
      exp_w[1] = 32'h55667788;
      do_start();
      send_header(3);
      send_word(exp_w[0], 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_cpu_hold", 32'(cpu_hold), 0);
      chk("mrst_in_ready", 32'(in_ready), 0);
      chk("mrst_we", 32'(mem_we), 0);
      chk("mrst_done", 32'(done), 0);
      chk("mrst_writes", 32'(wr_cnt), 1);
      chk("mrst_addr0", wa[0], 32'h0);
      chk("mrst_data0", wd[0], 32'h11223344);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("mrst_idle_busy", 32'(busy), 0);
      chk("mrst_no_write", 32'(wr_cnt), 1);
      $display("reset mid-load: %0d writes", wr_cnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
